aes_stim_gen: RTL and testbench

Synthesizable, parametrised stimulus sequencer for the pipelined AES core. It generates plaintext and key vectors from on-chip LFSRs or a counter, issues one vector per cycle for a programmable test count, and tracks in-flight encryptions by core latency. It reports completion with counts. It sits between a host/control register block and `aes_128`, replacing bench-only stimulus so that hardware runs can replay simulation traffic.

---
 rtl/aes_stim_gen.sv | 202 ++++++++++++++++++++
 tb/tb_aes_stim_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : aes_stim_gen
// Purpose  : Stimulus sequencer for the pipelined AES core. Generates
//            plaintext/key vectors from XNOR LFSRs or a counter, issues one
//            vector per cycle for a programmable count, tracks in-flight
//            results by core latency and reports completion with counts.
// Options  : AES_STIM_GEN_CHECKSUM_EN - build the XOR accumulator of all
//            tracked core outputs (otherwise checksum is tied to zero).
// Revision : 1.0 - initial release
// ============================================================================
module aes_stim_gen #(
    parameter int unsigned            DATA_WIDTH = 128,
    parameter int unsigned            LATENCY    = 21,
    parameter int unsigned            CNT_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]  STATE_SEED = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF,
    parameter logic [DATA_WIDTH-1:0]  KEY_SEED   = 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED,
    parameter logic [DATA_WIDTH-1:0]  TAP_MASK   = 128'hA000_0014_0000_0000_0000_0000_0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  num_tests,
    input  logic [DATA_WIDTH-1:0] fixed_key,
    output logic [DATA_WIDTH-1:0] aes_state,
    output logic [DATA_WIDTH-1:0] aes_key,
    output logic                  aes_valid,
    input  logic [DATA_WIDTH-1:0] core_out,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  issued_count,
    output logic [CNT_WIDTH-1:0]  completed_count,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_issue = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    // An all-ones seed locks an XNOR LFSR; refuse to elaborate with one.
    if (STATE_SEED == {DATA_WIDTH{1'b1}}) begin : g_state_seed_lockup
        $error("aes_stim_gen: STATE_SEED is all-ones (XNOR LFSR lockup)");
    end
    if (KEY_SEED == {DATA_WIDTH{1'b1}}) begin : g_key_seed_lockup
        $error("aes_stim_gen: KEY_SEED is all-ones (XNOR LFSR lockup)");
    end

    logic [2:0]            r_st;
    logic [2:0]            w_st_nx;
    logic [CNT_WIDTH-1:0]  r_num_tests;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_fixed_key;
    logic [DATA_WIDTH-1:0] r_aes_state;
    logic [DATA_WIDTH-1:0] r_aes_key;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [CNT_WIDTH-1:0]  r_completed;
    logic [LATENCY-1:0]    r_vpipe;

    logic                  w_issue;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_start_acc;
    logic                  w_rand_key;
    logic                  w_counter_mode;
    logic                  w_out_valid;
    logic [LATENCY-1:0]    w_vpipe_nx;
    logic [CNT_WIDTH-1:0]  w_completed_nx;
    logic [DATA_WIDTH-1:0] w_state_lfsr_nx;
    logic [DATA_WIDTH-1:0] w_key_lfsr_nx;

    assign w_start_acc     = (r_st == c_st_idle) && start;
    assign w_rand_key      = (r_mode == 2'b00) || (r_mode == 2'b11);
    assign w_counter_mode  = (r_mode == 2'b10);
    assign w_out_valid     = r_vpipe[LATENCY-1];
    assign w_vpipe_nx      = (r_vpipe << 1) | LATENCY'(w_issue);
    assign w_completed_nx  = (w_out_valid && (r_completed != c_cnt_max))
                             ? r_completed + c_cnt_one : r_completed;
    assign w_state_lfsr_nx = {r_aes_state[DATA_WIDTH-2:0], ~^(r_aes_state & TAP_MASK)};
    assign w_key_lfsr_nx   = {r_aes_key[DATA_WIDTH-2:0], ~^(r_aes_key & TAP_MASK)};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st <= c_st_idle;
        end else begin
            r_st <= w_st_nx;
        end
    end

    // Next-state logic; DRAIN exits once the last tracked result is retiring this cycle.
    always_comb begin
        w_st_nx = r_st;
        case (r_st)
            c_st_idle:  if (start) w_st_nx = (num_tests == '0) ? c_st_done : c_st_load;
            c_st_load:  w_st_nx = c_st_issue;
            c_st_issue: if (abort || (r_issued == r_num_tests - c_cnt_one)) w_st_nx = c_st_drain;
            c_st_drain: if ((w_vpipe_nx == '0) && (w_completed_nx == r_issued)) w_st_nx = c_st_done;
            c_st_done:  w_st_nx = c_st_idle;
            default:    w_st_nx = c_st_idle;
        endcase
    end

    // Output decode; an abort cycle issues nothing.
    always_comb begin
        w_issue = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (r_st)
            c_st_idle:  w_busy  = 1'b0;
            c_st_issue: w_issue = ~abort;
            c_st_done:  w_done  = 1'b1;
            default:    ;
        endcase
    end

    // Run configuration latched at start, plus saturating issue/complete counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_tests <= '0;
            r_mode      <= 2'b00;
            r_fixed_key <= '0;
            r_issued    <= '0;
            r_completed <= '0;
        end else if (w_start_acc) begin
            r_num_tests <= num_tests;
            r_mode      <= mode;
            r_fixed_key <= fixed_key;
            r_issued    <= '0;
            r_completed <= '0;
        end else begin
            if (w_issue && (r_issued != c_cnt_max)) begin
                r_issued <= r_issued + c_cnt_one;
            end
            r_completed <= w_completed_nx;
        end
    end

    // Vector generators: seeded in LOAD, advanced after every issued vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aes_state <= STATE_SEED;
            r_aes_key   <= KEY_SEED;
        end else if (r_st == c_st_load) begin
            r_aes_state <= STATE_SEED;
            r_aes_key   <= w_rand_key ? KEY_SEED : r_fixed_key;
        end else if (w_issue) begin
            r_aes_state <= w_counter_mode ? r_aes_state + DATA_WIDTH'(1) : w_state_lfsr_nx;
            if (w_rand_key) begin
                r_aes_key <= w_key_lfsr_nx;
            end
        end
    end

    // Valid tracker mirroring the core pipeline depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe <= w_vpipe_nx;
        end
    end

`ifdef AES_STIM_GEN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    // XOR accumulator over every tracked core result of the current run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_out_valid) begin
            r_checksum <= r_checksum ^ core_out;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign aes_state       = r_aes_state;
    assign aes_key         = r_aes_key;
    assign aes_valid       = w_issue;
    assign out_valid       = w_out_valid;
    assign out_data        = core_out;
    assign busy            = w_busy;
    assign done            = w_done;
    assign issued_count    = r_issued;
    assign completed_count = r_completed;

endmodule
`default_nettype wire

// File: tb/tb_aes_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_stim_gen
// Purpose  : Self-checking bench for aes_stim_gen: directed and randomised
//            runs compared cycle by cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_stim_gen;

    localparam int unsigned DW  = 128;
    localparam int unsigned LAT = 21;
    localparam int unsigned CW  = 32;
    localparam logic [DW-1:0] SSEED = {DW{1'b1}} - 128'd1;
    localparam logic [DW-1:0] KSEED = 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [CW-1:0] num_tests;
    logic [DW-1:0] fixed_key;
    logic [DW-1:0] core_out;
    logic [DW-1:0] aes_state;
    logic [DW-1:0] aes_key;
    logic          aes_valid;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] issued_count;
    logic [CW-1:0] completed_count;
    logic [DW-1:0] checksum;

    int total = 0;
    int bad   = 0;

    aes_stim_gen #(
        .DATA_WIDTH (DW),
        .LATENCY    (LAT),
        .CNT_WIDTH  (CW),
        .STATE_SEED (SSEED),
        .KEY_SEED   (KSEED)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .mode            (mode),
        .num_tests       (num_tests),
        .fixed_key       (fixed_key),
        .aes_state       (aes_state),
        .aes_key         (aes_key),
        .aes_valid       (aes_valid),
        .core_out        (core_out),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .busy            (busy),
        .done            (done),
        .issued_count    (issued_count),
        .completed_count (completed_count),
        .checksum        (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Shift left, new LSB = XNOR of bits 127,125,100,98.
    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] v);
        return {v[DW-2:0], ~(v[127] ^ v[125] ^ v[100] ^ v[98])};
    endfunction

    task automatic chk_reset_values();
        chk("rst_busy", busy, 1'b0);
        chk("rst_aes_valid", aes_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_issued", issued_count, '0);
        chk("rst_completed", completed_count, '0);
        chk("rst_checksum", checksum, '0);
        chk("rst_aes_state", aes_state, SSEED);
        chk("rst_aes_key", aes_key, KSEED);
    endtask

    // One run starting at cycle k=0. abort_at: issue-cycle number (>=2) that
    // sees abort, 0 for none. rst_at: cycle to apply reset and stop, -1 for none.
    task automatic run(input logic [1:0] m, input int n, input logic [DW-1:0] fk,
                       input int abort_at, input int rst_at);
        int            n_iss;
        int            done_k;
        logic          ctr;
        logic          rnd_key;
        logic          exp_v;
        logic          exp_ov;
        logic [DW-1:0] es;
        logic [DW-1:0] ek;
        logic [DW-1:0] csum;
        n_iss   = (abort_at > 0 && abort_at - 1 < n) ? abort_at - 1 : n;
        done_k  = (n == 0) ? 1 : 2 + LAT + n_iss;
        ctr     = (m == 2'b10);
        rnd_key = (m == 2'b00) || (m == 2'b11);
        es      = SSEED;
        ek      = rnd_key ? KSEED : fk;
        csum    = '0;
        for (int k = 0; k <= done_k + 1; k++) begin
            @(posedge clk);
            #1;
            start = (k == 0) || (k == 3 && n > 0);
            if (k == 0) begin
                mode      = m;
                num_tests = CW'(n);
                fixed_key = fk;
            end else begin
                mode      = 2'($urandom_range(3));
                num_tests = CW'($urandom);
                fixed_key = {$urandom, $urandom, $urandom, $urandom};
            end
            abort    = (abort_at > 0) && (k == 1 + abort_at);
            core_out = {$urandom, $urandom, $urandom, $urandom};
            if (k == rst_at) rst = 1'b1;
            @(negedge clk);
            if (k == rst_at) begin
                chk_reset_values();
                @(posedge clk);
                #1;
                rst   = 1'b0;
                start = 1'b0;
                abort = 1'b0;
                return;
            end
            exp_v  = (k >= 2) && (k < 2 + n_iss);
            exp_ov = (k >= 2 + int'(LAT)) && (k < 2 + int'(LAT) + n_iss);
            chk("aes_valid", aes_valid, exp_v);
            chk("out_valid", out_valid, exp_ov);
            chk("done", done, k == done_k);
            chk("busy", busy, (k >= 1) && (k <= done_k));
            if (exp_v) begin
                chk("aes_state", aes_state, es);
                chk("aes_key", aes_key, ek);
                es = ctr ? es + 128'd1 : lfsr_step(es);
                if (rnd_key) ek = lfsr_step(ek);
            end
            if (exp_ov) begin
                csum ^= core_out;
                chk("out_data", out_data, core_out);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        chk("issued_count", issued_count, DW'(n_iss));
        chk("completed_count", completed_count, DW'(n_iss));
`ifdef AES_STIM_GEN_CHECKSUM_EN
        chk("checksum", checksum, csum);
`else
        chk("checksum", checksum, '0);
`endif
    endtask

    initial begin
        int            rn;
        int            ra;
        logic [DW-1:0] fk;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 2'b00;
        num_tests = '0;
        fixed_key = '0;
        core_out  = '0;
        @(negedge clk);
        chk_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Mode 00, five vectors: first vector equals the seeds.
        run(2'b00, 5, 128'h0, 0, -1);
        // Mode 10 counter wraps FF..FE -> FF..FF -> 00..00 with fixed key.
        fk = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        run(2'b10, 3, fk, 0, -1);
        // Mode 01: LFSR state with fixed key.
        run(2'b01, 7, ~fk, 0, -1);
        // Zero tests: straight to DONE.
        run(2'b00, 0, fk, 0, -1);
        // Abort on the third issue cycle of a ten-vector run.
        run(2'b00, 10, fk, 3, -1);
        // Reserved mode behaves as mode 00.
        run(2'b11, 4, fk, 0, -1);
        // Reset while draining, then a clean run with no stale results.
        run(2'b00, 4, fk, 0, 9);
        run(2'b00, 6, fk, 0, -1);
        // Randomised runs, some with abort (possibly landing in DRAIN).
        for (int r = 0; r < 8; r++) begin
            rn = int'($urandom_range(8, 1));
            ra = ($urandom_range(3) == 0) ? int'($urandom_range(rn + 3, 2)) : 0;
            fk = {$urandom, $urandom, $urandom, $urandom};
            run(2'($urandom_range(3)), rn, fk, ra, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
